// File: rtl/line_unloader_pkg.sv
// Shared types and defaults for the line_unloader_8x64 capture/playback buffer.
package line_unloader_pkg;

    typedef enum logic {
        StFill  = 1'b0,
        StDrain = 1'b1
    } state_e;

    localparam int unsigned DefWidth   = 8;
    localparam int unsigned DefDepth   = 64;
    localparam int unsigned CountWidth = $clog2(DefDepth) + 1;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/line_unloader_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset on contents.
module line_unloader_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/line_unloader_8x64.sv
// Captures one line of up to DEPTH bytes, then plays it back with out_last marking.
// Define LINE_UNLOADER_REVERSE_EN for LIFO playback; FIFO order otherwise.
module line_unloader_8x64
    import line_unloader_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] count,
    output logic                   trunc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   len_q, len_d;
    logic            trunc_q, trunc_d;
    logic            wr_en;
    logic [AW-1:0]   rd_start;
    logic [AW-1:0]   rd_next;

`ifdef LINE_UNLOADER_REVERSE_EN
    // Before the closing byte is counted, count_q equals len-1: the last written slot.
    assign rd_start = count_q[AW-1:0];
    assign rd_next  = rd_ptr_q - 1'b1;
`else
    assign rd_start = '0;
    assign rd_next  = rd_ptr_q + 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        len_d     = len_q;
        trunc_d   = 1'b0;
        wr_en     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StFill: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                    if (in_last || (count_q == CW'(DEPTH - 1))) begin
                        state_d  = StDrain;
                        len_d    = count_q + 1'b1;
                        rd_ptr_d = rd_start;
                        trunc_d  = ~in_last;
                    end
                end
            end
            StDrain: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rd_ptr_d = rd_next;
                    count_d  = count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        state_d  = StFill;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StFill;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            len_q    <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            len_q    <= len_d;
            trunc_q  <= trunc_d;
        end
    end

    line_unloader_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk_i  (clk),
        .we_i   (wr_en),
        .waddr_i(wr_ptr_q),
        .wdata_i(in_data),
        .raddr_i(rd_ptr_q),
        .rdata_o(out_data)
    );

    assign out_last = (state_q == StDrain) && (count_q == CW'(1));
    assign count    = count_q;
    assign trunc    = trunc_q;

    // Remaining bytes can never exceed the latched line length during playback.
    assert property (@(posedge clk) disable iff (reset)
        (state_q == StDrain) |-> ((count_q != '0) && (count_q <= len_q)));

endmodule

// File: tb/tb_line_unloader_8x64.sv
// Randomized bench for line_unloader_8x64 against a queue-based line model.
module tb_line_unloader_8x64;

    localparam int W = 8;
    localparam int D = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic [W-1:0]         in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_data;
    logic                 out_last;
    logic [$clog2(D):0]   count;
    logic                 trunc;

    int n_chk = 0;
    int n_bad = 0;
    logic [7:0] line_q[$];

    always #5 clk = ~clk;

    line_unloader_8x64 #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .count    (count),
        .trunc    (trunc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Playback order of a captured line, straight from the ordering rule.
    function automatic void expected_order(input logic [7:0] cap[$], output logic [7:0] o[$]);
        o = {};
        foreach (cap[i]) begin
`ifdef LINE_UNLOADER_REVERSE_EN
            o.push_front(cap[i]);
`else
            o.push_back(cap[i]);
`endif
        end
    endfunction

    // bp: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random
    task automatic run_line(input int n, input bit with_last, input bit gaps, input int bp,
                            input bit hold_next);
        logic [7:0] cap[$];
        logic [7:0] exp_q[$];
        int idx;
        int budget;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            check("fill_ready", 32'(in_ready), 1);
            check("fill_outvalid", 32'(out_valid), 0);
            check("fill_count", 32'(count), i);
            check("fill_trunc", 32'(trunc), 0);
            in_valid = 1'b1;
            in_data  = line_q[i];
            in_last  = with_last && (i == n - 1);
            cap.push_back(line_q[i]);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("close_ready", 32'(in_ready), 0);
        check("close_outvalid", 32'(out_valid), 1);
        check("close_count", 32'(count), n);
        check("close_trunc", 32'(trunc), (n == D && !with_last) ? 1 : 0);
        expected_order(cap, exp_q);
        if (hold_next) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
            in_last  = 1'b0;
        end
        idx    = 0;
        budget = 0;
        while (idx < n && budget < 4 * n + 10) begin
            case (bp)
                0:       out_ready = 1'b1;
                1:       out_ready = (budget % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            check("drain_valid", 32'(out_valid), 1);
            check("drain_ready", 32'(in_ready), 0);
            check("drain_data", 32'(out_data), 32'(exp_q[idx]));
            check("drain_last", 32'(out_last), (idx == n - 1) ? 1 : 0);
            check("drain_count", 32'(count), n - idx);
            if (budget > 0) check("drain_trunc", 32'(trunc), 0);
            tick();
            if (out_ready) idx++;
            budget++;
        end
        out_ready = 1'b0;
        check("drain_done", idx, n);
        check("post_ready", 32'(in_ready), 1);
        check("post_outvalid", 32'(out_valid), 0);
        check("post_count", 32'(count), 0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_ready", 32'(in_ready), 1);
        check("rst_outvalid", 32'(out_valid), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_count", 32'(count), 0);
        check("rst_trunc", 32'(trunc), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Basic three-byte line
        line_q = {8'h10, 8'h11, 8'h12};
        run_line(3, 1'b1, 1'b0, 0, 1'b0);

        // Full line without in_last, then full line closed by in_last at DEPTH
        line_q = {};
        for (int i = 0; i < D; i++) line_q.push_back(8'(i));
        run_line(D, 1'b0, 1'b0, 0, 1'b0);
        run_line(D, 1'b1, 1'b0, 2, 1'b0);

        // Backpressure pattern 1,0,0
        line_q = {};
        for (int i = 0; i < 7; i++) line_q.push_back(8'($urandom));
        run_line(7, 1'b1, 1'b0, 1, 1'b0);

        // Single-byte line
        line_q = {8'hA5};
        run_line(1, 1'b1, 1'b0, 0, 1'b0);

        // Reset mid-drain after 2 of 5 bytes consumed
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = (i == 4);
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("mid_count", 32'(count), 3);
        #2 reset = 1'b1;
        #1;
        check("arst_outvalid", 32'(out_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_ready", 32'(in_ready), 1);
        check("arst_trunc", 32'(trunc), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        line_q = {8'h55};
        run_line(1, 1'b1, 1'b0, 0, 1'b0);

        // Back-to-back: in_valid held through drain with 0xEE, which starts the next line
        line_q = {8'h21, 8'h22, 8'h23, 8'h24};
        run_line(4, 1'b1, 1'b0, 1, 1'b1);
        line_q = {8'hEE, 8'h31, 8'h32};
        run_line(3, 1'b1, 1'b0, 0, 1'b0);

        // Random lines with input gaps and random backpressure
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, D);
            line_q = {};
            for (int i = 0; i < n; i++) line_q.push_back(8'($urandom));
            run_line(n, 1'b1, 1'b1, 2, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
